// File: rtl/vga_timing_rx.sv
// vga_timing_rx: follows an incoming h_sync / v_sync / display-enable raster and
// recovers pixel column/row, line and frame strobes, line errors and lock state.
module vga_timing_rx #(
  parameter int   H_BITS      = 7,
  parameter int   V_BITS      = 5,
  parameter int   H_PIXELS    = 50,
  parameter int   V_PIXELS    = 25,
  parameter int   H_PERIOD    = 66,
  parameter int   V_PERIOD    = 28,
  parameter logic H_POL       = 1'b0,
  parameter logic V_POL       = 1'b1,
  parameter int   SYNC_MIN    = 3,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              de_in,
  output logic [H_BITS-1:0] col,
  output logic [V_BITS-1:0] row,
  output logic              pix_valid,
  output logic              line_start,
  output logic              frame_start,
  output logic              locked,
  output logic              err_line
);

  localparam int RUN_BITS  = $clog2(SYNC_MIN + 1);
  localparam int GOOD_BITS = $clog2(LOCK_FRAMES + 1);

  localparam logic [RUN_BITS-1:0]  RUN_SAT   = RUN_BITS'(SYNC_MIN);
  localparam logic [RUN_BITS-1:0]  RUN_LAST  = RUN_BITS'(SYNC_MIN - 1);
  localparam logic [H_BITS-1:0]    H_MAX     = {H_BITS{1'b1}};
  localparam logic [H_BITS-1:0]    H_LAST    = H_BITS'(H_PERIOD - 1);
  localparam logic [H_BITS-1:0]    COL_SAT   = H_BITS'(H_PIXELS);
  localparam logic [V_BITS-1:0]    V_MAX     = {V_BITS{1'b1}};
  localparam logic [V_BITS-1:0]    V_LINES   = V_BITS'(V_PERIOD);
  localparam logic [V_BITS-1:0]    ROW_SAT   = V_BITS'(V_PIXELS);
  localparam logic [GOOD_BITS-1:0] GOOD_LOCK = GOOD_BITS'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t               state, next_state;
  logic [GOOD_BITS-1:0] good, good_next;

  logic                h_r, v_r, de_r, de_d;
  logic                h_act, v_act, h_det, v_det;
  logic [RUN_BITS-1:0] h_run, v_run;
  logic [H_BITS-1:0]   h_cnt;
  logic [V_BITS-1:0]   v_lines;
  logic                h_seen, err_seen, frame_ok;
  logic                err_det, frame_ok_c, h_sat, enter_search;
  logic [H_BITS-1:0]   col_cnt, col_next;
  logic [V_BITS-1:0]   row_cnt;
  logic                valid_c;

  // Reset the sync samples to their inactive level so release is not a pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_r  <= ~H_POL;
      v_r  <= ~V_POL;
      de_r <= 1'b0;
      de_d <= 1'b0;
    end else begin
      h_r  <= h_sync_in;
      v_r  <= v_sync_in;
      de_r <= de_in;
      de_d <= de_r;
    end
  end

  assign h_act = (h_r == H_POL);
  assign v_act = (v_r == V_POL);
  assign h_det = h_act && (h_run == RUN_LAST);
  assign v_det = v_act && (v_run == RUN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_run <= '0;
      v_run <= '0;
    end else begin
      if (!h_act)                h_run <= '0;
      else if (h_run != RUN_SAT) h_run <= h_run + 1'b1;
      if (!v_act)                v_run <= '0;
      else if (v_run != RUN_SAT) v_run <= v_run + 1'b1;
    end
  end

  assign h_sat        = (h_cnt == H_MAX);
  assign err_det      = h_det && h_seen && (h_cnt != H_LAST);
  assign frame_ok_c   = (v_lines == V_LINES) && !err_seen && !err_det;
  assign enter_search = (next_state == SEARCH) && (state != SEARCH);

  // Line/frame measurement; frame_ok captures the verdict for the FSM a cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt    <= '0;
      v_lines  <= '0;
      h_seen   <= 1'b0;
      err_seen <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      if (h_det)              h_cnt <= '0;
      else if (!h_sat)        h_cnt <= h_cnt + 1'b1;

      if (v_det)              v_lines <= h_det ? V_BITS'(1) : '0;
      else if (h_det && v_lines != V_MAX) v_lines <= v_lines + 1'b1;

      if (enter_search)       h_seen <= 1'b0;
      else if (h_det)         h_seen <= 1'b1;

      if (v_det) begin
        frame_ok <= frame_ok_c;
        err_seen <= 1'b0;
      end else if (err_det) begin
        err_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    col_next = col_cnt;
    if (de_r) begin
      if (!de_d)                  col_next = '0;
      else if (col_cnt != COL_SAT) col_next = col_cnt + 1'b1;
    end
  end

  assign valid_c = de_r && (col_next < COL_SAT) && (row_cnt < ROW_SAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      col         <= '0;
      row         <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      err_line    <= 1'b0;
    end else begin
      col_cnt <= col_next;
      if (v_det)                                     row_cnt <= '0;
      else if (de_d && !de_r && row_cnt != ROW_SAT) row_cnt <= row_cnt + 1'b1;
      if (valid_c) begin
        col <= col_next;
        row <= row_cnt;
      end
      pix_valid   <= valid_c;
      line_start  <= h_det;
      frame_start <= v_det;
      err_line    <= err_det;
    end
  end

  // The FSM works from the registered strobes, so lock changes trail them by one clock
  always_comb begin
    next_state = state;
    good_next  = good;
    unique case (state)
      SEARCH: begin
        if (frame_start) begin
          next_state = VERIFY;
          good_next  = '0;
        end
      end
      VERIFY: begin
        if (h_sat) begin
          next_state = SEARCH;
          good_next  = '0;
        end else if (frame_start) begin
          if (frame_ok) begin
            good_next = good + 1'b1;
            if (good_next == GOOD_LOCK) next_state = LOCKED;
          end else begin
            good_next = '0;
          end
        end
      end
      LOCKED: begin
        if (err_line || h_sat || (frame_start && !frame_ok)) next_state = SEARCH;
      end
      default: next_state = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SEARCH;
      good   <= '0;
      locked <= 1'b0;
    end else begin
      state  <= next_state;
      good   <= good_next;
      locked <= (next_state == LOCKED);
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Testbench for vga_timing_rx: drives a directed 66x28 raster and checks strobes,
// pixel coordinates and lock behaviour through expectation queues.
module tb_vga_timing_rx;

  localparam int H_BITS = 7;
  localparam int V_BITS = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              h_sync_in, v_sync_in, de_in;
  logic [H_BITS-1:0] col;
  logic [V_BITS-1:0] row;
  logic              pix_valid, line_start, frame_start, locked, err_line;

  vga_timing_rx dut (
    .clk(clk), .rst(rst), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .de_in(de_in),
    .col(col), .row(row), .pix_valid(pix_valid), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .err_line(err_line)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic chk_lock; } ls_exp_t;
  typedef struct packed { logic [H_BITS-1:0] col; logic [V_BITS-1:0] row; } px_exp_t;

  ls_exp_t ls_q[$];
  logic    fs_q[$];
  px_exp_t px_q[$];

  int total = 0;
  int bad   = 0;
  bit aborted = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_col"}, col, 0);
    checkOutput({tag, "_row"}, row, 0);
    checkOutput({tag, "_pix_valid"}, pix_valid, 0);
    checkOutput({tag, "_line_start"}, line_start, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_err_line"}, err_line, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or pixel
  logic    fs_pend = 0, fs_val = 0, ls_pend = 0;
  ls_exp_t ls_e;
  px_exp_t px_e;
  logic    fs_e;

  always @(negedge clk) begin
    if (rst) begin
      fs_pend = 0;
      ls_pend = 0;
    end else begin
      if (fs_pend) begin
        checkOutput("locked_after_frame_start", locked, fs_val);
        fs_pend = 0;
      end
      if (ls_pend) begin
        checkOutput("locked_after_err_line", locked, 0);
        ls_pend = 0;
      end
      if (line_start) begin
        checkOutput("line_start_expected", int'(ls_q.size() > 0), 1);
        if (ls_q.size() > 0) begin
          ls_e = ls_q.pop_front();
          checkOutput("err_line", err_line, ls_e.err);
          if (ls_e.chk_lock) ls_pend = 1;
        end
      end else if (err_line) begin
        checkOutput("err_line_without_line_start", err_line, 0);
      end
      if (frame_start) begin
        checkOutput("frame_start_expected", int'(fs_q.size() > 0), 1);
        if (fs_q.size() > 0) begin
          fs_e    = fs_q.pop_front();
          fs_val  = fs_e;
          fs_pend = 1;
        end
      end
      if (pix_valid) begin
        checkOutput("pix_valid_expected", int'(px_q.size() > 0), 1);
        if (px_q.size() > 0) begin
          px_e = px_q.pop_front();
          checkOutput("col", col, px_e.col);
          checkOutput("row", row, px_e.row);
        end
      end
    end
  end

  task automatic drive(input logic h, input logic v, input logic de);
    @(posedge clk);
    #1;
    h_sync_in = h;
    v_sync_in = v;
    de_in     = de;
  endtask

  task automatic midReset();
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midframe_reset");
    ls_q.delete();
    fs_q.delete();
    px_q.delete();
    h_sync_in = 1'b1;
    v_sync_in = 1'b0;
    de_in     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    aborted = 1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("locked_after_reset_release", locked, 0);
  endtask

  // One line: h pulse low for hpw clocks, single-cycle glitches at p=30 (h) and p=40 (v)
  task automatic applyStimulus(input int len, input int hpw, input bit vline, input bit vis,
                               input int rown, input bit exp_err, input int abort_p);
    logic h, v, de;
    for (int p = 0; p < len; p++) begin
      h  = !((p < hpw) || (p == 30));
      v  = vline || (p == 40);
      de = vis && (p >= 8) && (p < 58);
      drive(h, v, de);
      if (p == 0 && hpw >= 3) ls_q.push_back(ls_exp_t'{err: exp_err, chk_lock: exp_err});
      if (de) px_q.push_back(px_exp_t'{col: H_BITS'(p - 8), row: V_BITS'(rown)});
      if (p == abort_p) begin
        midReset();
        return;
      end
    end
  endtask

  task automatic sendFrame(input int nlines, input bit exp_lock, input int short_i,
                           input int long_i, input int abort_i);
    int len, hpw;
    aborted = 0;
    for (int i = 0; i < nlines && !aborted; i++) begin
      if (i == 0) fs_q.push_back(exp_lock);
      len = (i == short_i) ? 65 : ((i == long_i) ? 140 : 66);
      hpw = (i == long_i) ? 0 : 5;
      applyStimulus(len, hpw, i == 0, (i >= 2) && (i <= 26), i - 2,
                    (short_i >= 0) && (i == short_i + 1), (i == abort_i) ? 20 : -1);
      if (i == long_i) checkOutput("locked_after_hsync_loss", locked, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    h_sync_in = 1'b1;
    v_sync_in = 1'b0;
    de_in     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (4) drive(1'b1, 1'b0, 1'b0);

    applyStimulus(66, 2, 1'b0, 1'b0, 0, 1'b0, -1);

    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b1, -1, -1, -1);
    sendFrame(28, 1'b1, -1, -1, -1);
    sendFrame(28, 1'b1, 10, -1, -1);
    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b1, -1, -1, -1);
    sendFrame(27, 1'b1, -1, -1, -1);
    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b1, -1, 1, -1);
    sendFrame(28, 1'b0, -1, -1, 14);
    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b0, -1, -1, -1);
    sendFrame(28, 1'b1, -1, -1, -1);

    repeat (10) drive(1'b1, 1'b0, 1'b0);
    checkOutput("pending_line_starts", ls_q.size(), 0);
    checkOutput("pending_frame_starts", fs_q.size(), 0);
    checkOutput("pending_pixels", px_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
